// File: rtl/ptp_ts_monitor.sv
// PTP time bus receive-side monitor: checks increments, format, PPS alignment,
// counts PPS/steps and captures timestamps on demand.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ts_tod[95:0]    ToD {sec[47:0], ns[31:0], fns[15:0]}
//   ts_rel[63:0]    relative time {ns[47:0], fns[15:0]}
//   ts_step         sample is a discontinuity
//   pps             pulse coincident with a seconds increment
//   capture         latch the current sample
//   err_clear       clear sticky flags (travels with its sample)
//   capture_tod/rel latched sample, capture_valid one-cycle pulse
//   inc, inc_valid  last relative increment in fns
//   err_*           sticky error flags
//   pps_count       saturating PPS count
//   step_count      saturating step count
module ptp_ts_monitor #(
  parameter int unsigned INC_TOL      = 0,
  parameter bit          PPS_CHECK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] ts_tod,
  input  logic [63:0] ts_rel,
  input  logic        ts_step,
  input  logic        pps,
  input  logic        capture,
  input  logic        err_clear,
  output logic [95:0] capture_tod,
  output logic [63:0] capture_rel,
  output logic        capture_valid,
  output logic [31:0] inc,
  output logic        inc_valid,
  output logic        err_ns_range,
  output logic        err_backwards,
  output logic        err_mismatch,
  output logic        err_pps,
  output logic [31:0] pps_count,
  output logic [15:0] step_count
);

  localparam logic [65:0] SEC_FNS = 66'd65536000000000;
  localparam logic [31:0] NS_MAX  = 32'd1000000000;

  // stage 1: sample registers
  logic [95:0] cur_tod_q, prev_tod_q;
  logic [63:0] cur_rel_q, prev_rel_q;
  logic        cur_step_q, cur_pps_q, cur_cap_q, cur_clr_q;
  logic        cur_vld_q, prev_vld_q;

  // stage 2: result registers
  logic [95:0] cap_tod_q, cap_tod_d;
  logic [63:0] cap_rel_q, cap_rel_d;
  logic        cap_vld_q, cap_vld_d;
  logic [31:0] inc_q, inc_d;
  logic        inc_vld_q, inc_vld_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] pps_cnt_q, pps_cnt_d;
  logic [15:0] step_cnt_q, step_cnt_d;

  logic [47:0] cur_sec, prev_sec, cur_nf, prev_nf;
  logic [48:0] sec_diff;
  logic        sec_same, sec_inc;
  logic [63:0] d_rel;
  logic [65:0] d_tod, diff, abs_diff;
  logic        chk, new_rng, new_bwd, new_mm, new_pps, clr;

  always_comb begin
    cur_sec  = cur_tod_q[95:48];
    prev_sec = prev_tod_q[95:48];
    cur_nf   = cur_tod_q[47:0];
    prev_nf  = prev_tod_q[47:0];
    // 49-bit difference so that a 48-bit seconds wrap is not an increment
    sec_diff = {1'b0, cur_sec} - {1'b0, prev_sec};
    sec_same = (sec_diff == 49'd0);
    sec_inc  = (sec_diff == 49'd1);
    d_rel    = cur_rel_q - prev_rel_q;
    d_tod    = {18'd0, cur_nf} - {18'd0, prev_nf};
    if (sec_inc) d_tod = d_tod + SEC_FNS;
    diff     = d_tod - {{2{d_rel[63]}}, d_rel};
    abs_diff = diff[65] ? (66'd0 - diff) : diff;

    chk     = cur_vld_q & prev_vld_q & ~cur_step_q;
    new_rng = cur_vld_q & (cur_tod_q[47:16] >= NS_MAX);
    new_bwd = chk & (d_rel[63] | ~(sec_same | sec_inc) |
              (sec_same & (cur_nf < prev_nf)));
    new_mm  = chk & ~new_bwd & (abs_diff > 66'(INC_TOL));
    new_pps = PPS_CHECK_EN & chk & (cur_pps_q != sec_inc);
    clr     = cur_vld_q & cur_clr_q;

    // a new error wins over a clear on the same sample
    flags_d = (flags_q & {4{~clr}}) |
              {new_rng, new_bwd, new_mm, new_pps};

    inc_vld_d = chk;
    inc_d     = chk ? d_rel[31:0] : inc_q;

    cap_vld_d = cur_vld_q & cur_cap_q;
    cap_tod_d = cap_vld_d ? cur_tod_q : cap_tod_q;
    cap_rel_d = cap_vld_d ? cur_rel_q : cap_rel_q;

    pps_cnt_d = pps_cnt_q;
    if (cur_vld_q & cur_pps_q & ~&pps_cnt_q)
      pps_cnt_d = pps_cnt_q + 32'd1;
    step_cnt_d = step_cnt_q;
    if (cur_vld_q & cur_step_q & ~&step_cnt_q)
      step_cnt_d = step_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_tod_q  <= '0;
      cur_rel_q  <= '0;
      cur_step_q <= 1'b0;
      cur_pps_q  <= 1'b0;
      cur_cap_q  <= 1'b0;
      cur_clr_q  <= 1'b0;
      cur_vld_q  <= 1'b0;
      prev_tod_q <= '0;
      prev_rel_q <= '0;
      prev_vld_q <= 1'b0;
      cap_tod_q  <= '0;
      cap_rel_q  <= '0;
      cap_vld_q  <= 1'b0;
      inc_q      <= '0;
      inc_vld_q  <= 1'b0;
      flags_q    <= '0;
      pps_cnt_q  <= '0;
      step_cnt_q <= '0;
    end else begin
      cur_tod_q  <= ts_tod;
      cur_rel_q  <= ts_rel;
      cur_step_q <= ts_step;
      cur_pps_q  <= pps;
      cur_cap_q  <= capture;
      cur_clr_q  <= err_clear;
      cur_vld_q  <= 1'b1;
      prev_tod_q <= cur_tod_q;
      prev_rel_q <= cur_rel_q;
      prev_vld_q <= cur_vld_q;
      cap_tod_q  <= cap_tod_d;
      cap_rel_q  <= cap_rel_d;
      cap_vld_q  <= cap_vld_d;
      inc_q      <= inc_d;
      inc_vld_q  <= inc_vld_d;
      flags_q    <= flags_d;
      pps_cnt_q  <= pps_cnt_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign capture_tod   = cap_tod_q;
  assign capture_rel   = cap_rel_q;
  assign capture_valid = cap_vld_q;
  assign inc           = inc_q;
  assign inc_valid     = inc_vld_q;
  assign err_ns_range  = flags_q[3];
  assign err_backwards = flags_q[2];
  assign err_mismatch  = flags_q[1];
  assign err_pps       = flags_q[0];
  assign pps_count     = pps_cnt_q;
  assign step_count    = step_cnt_q;

endmodule
